// File: rtl/vx_rop_blend_multadd_pkg.sv
// Shared ROP definitions for the blend stage.
// Contents:
//   ROP_BLEND_MODE_*     blend equation encodings (ROP_BLEND_MODE_BITS wide)
//   ROP_BLEND_FUNC_*     blend factor selectors used by the factor stage
//   rgba_t               packed 8-bit-per-channel colour
//   div255_round()       exact rounded division of a 16-bit product by 255
package vx_rop_blend_multadd_pkg;

    localparam int ROP_BLEND_MODE_BITS = 3;

    localparam logic [ROP_BLEND_MODE_BITS-1:0] ROP_BLEND_MODE_ADD          = 3'd0;
    localparam logic [ROP_BLEND_MODE_BITS-1:0] ROP_BLEND_MODE_SUBTRACT     = 3'd1;
    localparam logic [ROP_BLEND_MODE_BITS-1:0] ROP_BLEND_MODE_REV_SUBTRACT = 3'd2;
    localparam logic [ROP_BLEND_MODE_BITS-1:0] ROP_BLEND_MODE_MIN          = 3'd3;
    localparam logic [ROP_BLEND_MODE_BITS-1:0] ROP_BLEND_MODE_MAX          = 3'd4;

    localparam int ROP_BLEND_FUNC_BITS = 4;

    localparam logic [ROP_BLEND_FUNC_BITS-1:0] ROP_BLEND_FUNC_ZERO                = 4'd0;
    localparam logic [ROP_BLEND_FUNC_BITS-1:0] ROP_BLEND_FUNC_ONE                 = 4'd1;
    localparam logic [ROP_BLEND_FUNC_BITS-1:0] ROP_BLEND_FUNC_SRC_RGB             = 4'd2;
    localparam logic [ROP_BLEND_FUNC_BITS-1:0] ROP_BLEND_FUNC_ONE_MINUS_SRC_RGB   = 4'd3;
    localparam logic [ROP_BLEND_FUNC_BITS-1:0] ROP_BLEND_FUNC_DST_RGB             = 4'd4;
    localparam logic [ROP_BLEND_FUNC_BITS-1:0] ROP_BLEND_FUNC_ONE_MINUS_DST_RGB   = 4'd5;
    localparam logic [ROP_BLEND_FUNC_BITS-1:0] ROP_BLEND_FUNC_SRC_A               = 4'd6;
    localparam logic [ROP_BLEND_FUNC_BITS-1:0] ROP_BLEND_FUNC_ONE_MINUS_SRC_A     = 4'd7;
    localparam logic [ROP_BLEND_FUNC_BITS-1:0] ROP_BLEND_FUNC_DST_A               = 4'd8;
    localparam logic [ROP_BLEND_FUNC_BITS-1:0] ROP_BLEND_FUNC_ONE_MINUS_DST_A     = 4'd9;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgba_t;

    // ((x+128) + ((x+128)>>8)) >> 8. The largest intermediate (65407) still
    // fits in 16 bits, so bits [15:8] hold the whole 8-bit quotient.
    function automatic logic [7:0] div255_round(input logic [15:0] x);
        logic [16:0] t;
        t = 17'(x) + 17'd128;
        t = t + (t >> 8);
        return t[15:8];
    endfunction

endpackage

// File: rtl/vx_rop_blend_channel.sv
// One 8-bit blend lane: S1 multiply, S2 normalize by 255, S3 combine + register.
// Ports:
//   clk, reset_n            clock, async active-low reset (output register only)
//   en                      global pipeline enable (low = hold every stage)
//   mode                    blend equation for this lane, captured with the beat
//   src, dst                raw colour channel values
//   src_factor, dst_factor  blend factors for this lane
//   result                  registered blended value (S3)
module vx_rop_blend_channel
    import vx_rop_blend_multadd_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           en,
    input  logic [ROP_BLEND_MODE_BITS-1:0] mode,
    input  logic [7:0]                     src,
    input  logic [7:0]                     dst,
    input  logic [7:0]                     src_factor,
    input  logic [7:0]                     dst_factor,
    output logic [7:0]                     result
);

    logic [ROP_BLEND_MODE_BITS-1:0] mode_s1, mode_s2;
    logic [15:0]                    ps_s1, pd_s1;
    logic [7:0]                     src_s1, dst_s1;
    logic [7:0]                     ns_s2, nd_s2;
    logic [7:0]                     src_s2, dst_s2;

    // NOTE: datapath registers are deliberately unreset; only the valid bits
    // (in the top) and the output register need a defined value after reset.
    always_ff @(posedge clk) begin
        if (en) begin
            mode_s1 <= mode;
            ps_s1   <= src * src_factor;
            pd_s1   <= dst * dst_factor;
            src_s1  <= src;
            dst_s1  <= dst;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mode_s2 <= mode_s1;
            ns_s2   <= div255_round(ps_s1);
            nd_s2   <= div255_round(pd_s1);
            src_s2  <= src_s1;
            dst_s2  <= dst_s1;
        end
    end

    logic [8:0]        sum;
    logic signed [8:0] diff_sd;
    logic signed [8:0] diff_ds;
    logic [7:0]        combined;

    // NOTE: every always_comb output gets a default first so no path can
    // infer a latch; undefined modes fall through to that zero.
    always_comb begin
        sum      = {1'b0, ns_s2} + {1'b0, nd_s2};
        diff_sd  = $signed({1'b0, ns_s2}) - $signed({1'b0, nd_s2});
        diff_ds  = $signed({1'b0, nd_s2}) - $signed({1'b0, ns_s2});
        combined = '0;
        case (mode_s2)
            ROP_BLEND_MODE_ADD:          combined = sum[8] ? 8'hFF : sum[7:0];
            ROP_BLEND_MODE_SUBTRACT:     combined = diff_sd[8] ? 8'h00 : diff_sd[7:0];
            ROP_BLEND_MODE_REV_SUBTRACT: combined = diff_ds[8] ? 8'h00 : diff_ds[7:0];
            ROP_BLEND_MODE_MIN:          combined = (src_s2 < dst_s2) ? src_s2 : dst_s2;
            ROP_BLEND_MODE_MAX:          combined = (src_s2 > dst_s2) ? src_s2 : dst_s2;
            default:                     combined = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result <= '0;
        end else if (en) begin
            result <= combined;
        end
    end

endmodule

// File: rtl/vx_rop_blend_multadd.sv
// ROP blend multiply-add: 3-stage valid/ready pipeline applying the blend
// equation per channel (b, g, r use mode_rgb; a uses mode_a).
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   valid_in / ready_in               input handshake
//   mode_rgb, mode_a                  blend equations, captured with the beat
//   src_color, dst_color              source / destination colours
//   src_factor, dst_factor            per-channel blend factors
//   tag_in / tag_out                  opaque tag travelling with the beat
//   valid_out / ready_out             output handshake
//   color_out                         blended colour
module vx_rop_blend_multadd
    import vx_rop_blend_multadd_pkg::*;
#(
    parameter int TAG_WIDTH = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           valid_in,
    output logic                           ready_in,
    input  logic [ROP_BLEND_MODE_BITS-1:0] mode_rgb,
    input  logic [ROP_BLEND_MODE_BITS-1:0] mode_a,
    input  rgba_t                          src_color,
    input  rgba_t                          dst_color,
    input  rgba_t                          src_factor,
    input  rgba_t                          dst_factor,
    input  logic [TAG_WIDTH-1:0]           tag_in,
    output logic                           valid_out,
    input  logic                           ready_out,
    output rgba_t                          color_out,
    output logic [TAG_WIDTH-1:0]           tag_out
);

    // A single enable for every stage: the pipeline only stalls when the
    // output holds a beat nobody takes, so bubbles ahead of it still shift
    // whenever en is high.
    logic stall;
    logic en;

    assign stall    = valid_out & ~ready_out;
    assign en       = ~stall;
    assign ready_in = en;

    logic                 valid_s1, valid_s2;
    logic [TAG_WIDTH-1:0] tag_s1, tag_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_s1  <= 1'b0;
            valid_s2  <= 1'b0;
            valid_out <= 1'b0;
            tag_out   <= '0;
        end else if (en) begin
            valid_s1  <= valid_in;
            valid_s2  <= valid_s1;
            valid_out <= valid_s2;
            tag_out   <= tag_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            tag_s1 <= tag_in;
            tag_s2 <= tag_s1;
        end
    end

    vx_rop_blend_channel u_ch_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .mode       (mode_rgb),
        .src        (src_color.b),
        .dst        (dst_color.b),
        .src_factor (src_factor.b),
        .dst_factor (dst_factor.b),
        .result     (color_out.b)
    );

    vx_rop_blend_channel u_ch_g (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .mode       (mode_rgb),
        .src        (src_color.g),
        .dst        (dst_color.g),
        .src_factor (src_factor.g),
        .dst_factor (dst_factor.g),
        .result     (color_out.g)
    );

    vx_rop_blend_channel u_ch_r (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .mode       (mode_rgb),
        .src        (src_color.r),
        .dst        (dst_color.r),
        .src_factor (src_factor.r),
        .dst_factor (dst_factor.r),
        .result     (color_out.r)
    );

    vx_rop_blend_channel u_ch_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .mode       (mode_a),
        .src        (src_color.a),
        .dst        (dst_color.a),
        .src_factor (src_factor.a),
        .dst_factor (dst_factor.a),
        .result     (color_out.a)
    );

endmodule
